// File: rtl/fpu_sub_arbiter_if.sv
// Requester, response and shared-subtractor signals of the two-port FPU subtract arbiter.
// The slave modport is the arbiter side; the master modport is the requester/subtractor side.
interface fpu_sub_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [63:0] req0_a;
    logic [63:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [63:0] req1_a;
    logic [63:0] req1_b;
    logic        resp0_valid;
    logic        resp0_ready;
    logic        resp1_valid;
    logic        resp1_ready;
    logic [63:0] resp_data;
    logic [63:0] sub_a;
    logic [63:0] sub_b;
    logic [63:0] sub_c;
    logic        busy;
    logic [15:0] ops_done;

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        input  resp0_ready, resp1_ready, sub_c,
        output req0_ready, req1_ready, resp0_valid, resp1_valid,
        output resp_data, sub_a, sub_b, busy, ops_done
    );

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        output resp0_ready, resp1_ready, sub_c,
        input  req0_ready, req1_ready, resp0_valid, resp1_valid,
        input  resp_data, sub_a, sub_b, busy, ops_done
    );
endinterface

// File: rtl/fpu_sub_arbiter.sv
// Round-robin arbiter sharing one FP subtractor between two requesters; response valid LATENCY+1
// edges after the request handshake; one op in flight, requests stalled until the response is taken.
module fpu_sub_arbiter #(
    parameter int LATENCY = 1  // subtractor settle cycles, legal 1..15
) (
    input  logic             clk,
    input  logic             rst,
    fpu_sub_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t      state_q, state_d;
    logic        rr_q;
    logic        gnt_q;
    logic [3:0]  cnt_q;
    logic [63:0] sub_a_q;
    logic [63:0] sub_b_q;
    logic [63:0] resp_data_q;
    logic [15:0] ops_q;
    logic        grant0, grant1;
    logic        req_hs, resp_hs;

    always_comb begin
        state_d = state_q;
        grant0  = 1'b0;
        grant1  = 1'b0;
        req_hs  = 1'b0;
        resp_hs = 1'b0;
        case (state_q)
            IDLE: begin
                // lone requester wins; on contention rr picks the port
                grant0 = bus.req0_valid & (~bus.req1_valid | ~rr_q);
                grant1 = bus.req1_valid & (~bus.req0_valid | rr_q);
                req_hs = grant0 | grant1;
                if (req_hs) state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd1) state_d = RESP;
            end
            RESP: begin
                resp_hs = gnt_q ? bus.resp1_ready : bus.resp0_ready;
                if (resp_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q        <= 1'b0;
            gnt_q       <= 1'b0;
            cnt_q       <= 4'd0;
            sub_a_q     <= 64'd0;
            sub_b_q     <= 64'd0;
            resp_data_q <= 64'd0;
            ops_q       <= 16'd0;
        end else begin
            if (req_hs) begin
                sub_a_q <= grant1 ? bus.req1_a : bus.req0_a;
                sub_b_q <= grant1 ? bus.req1_b : bus.req0_b;
                gnt_q   <= grant1;
                cnt_q   <= LAT;
            end
            if (state_q == WAIT) begin
                cnt_q <= cnt_q - 4'd1;
                if (cnt_q == 4'd1) resp_data_q <= bus.sub_c;
            end
            if (resp_hs) begin
                rr_q  <= ~gnt_q;
                ops_q <= ops_q + 16'd1;
            end
        end
    end

    // rst masks every handshake output so nothing is offered while reset is applied
    assign bus.req0_ready  = grant0 & ~rst;
    assign bus.req1_ready  = grant1 & ~rst;
    assign bus.resp0_valid = (state_q == RESP) & ~gnt_q & ~rst;
    assign bus.resp1_valid = (state_q == RESP) &  gnt_q & ~rst;
    assign bus.busy        = (state_q != IDLE) & ~rst;
    assign bus.resp_data   = resp_data_q;
    assign bus.sub_a       = sub_a_q;
    assign bus.sub_b       = sub_b_q;
    assign bus.ops_done    = ops_q;
endmodule

// File: tb/tb_fpu_sub_arbiter.sv
// Directed vectors for the FPU subtract arbiter at LATENCY=1 and LATENCY=4,
// with an ideal double-precision subtractor attached to each instance.
module tb_fpu_sub_arbiter;
    localparam logic [63:0] D_3P0  = 64'h4008000000000000;
    localparam logic [63:0] D_1P0  = 64'h3FF0000000000000;
    localparam logic [63:0] D_2P0  = 64'h4000000000000000;
    localparam logic [63:0] D_M2P0 = 64'hC000000000000000;
    localparam logic [63:0] D_10P0 = 64'h4024000000000000;
    localparam logic [63:0] D_0P25 = 64'h3FD0000000000000;
    localparam logic [63:0] D_9P75 = 64'h4023800000000000;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    fpu_sub_arbiter_if bus1 ();
    fpu_sub_arbiter_if bus4 ();

    fpu_sub_arbiter #(.LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    fpu_sub_arbiter #(.LATENCY(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    assign bus1.sub_c = $realtobits($bitstoreal(bus1.sub_a) - $bitstoreal(bus1.sub_b));
    assign bus4.sub_c = $realtobits($bitstoreal(bus4.sub_a) - $bitstoreal(bus4.sub_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        port;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] diff;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one full transaction on the LATENCY=1 instance
    task automatic do_op(input logic port, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_d, input logic [15:0] exp_ops);
        int n;
        step();
        if (port) begin bus1.req1_valid = 1'b1; bus1.req1_a = a; bus1.req1_b = b; end
        else      begin bus1.req0_valid = 1'b1; bus1.req0_a = a; bus1.req0_b = b; end
        #1;
        n = 0;
        while (!(port ? bus1.req1_ready : bus1.req0_ready) && n < 20) begin step(); n++; end
        chk("op_grant", {63'd0, n < 20}, 64'd1);
        chk("op_other_ready", {63'd0, port ? bus1.req0_ready : bus1.req1_ready}, 64'd0);
        step();
        bus1.req0_valid = 1'b0;
        bus1.req1_valid = 1'b0;
        n = 1;
        while (!(port ? bus1.resp1_valid : bus1.resp0_valid) && n < 20) begin step(); n++; end
        chk("op_latency", 64'(n), 64'd2);
        chk("op_data", bus1.resp_data, exp_d);
        chk("op_other_valid", {63'd0, port ? bus1.resp0_valid : bus1.resp1_valid}, 64'd0);
        chk("op_busy", {63'd0, bus1.busy}, 64'd1);
        if (port) bus1.resp1_ready = 1'b1; else bus1.resp0_ready = 1'b1;
        step();
        bus1.resp0_ready = 1'b0;
        bus1.resp1_ready = 1'b0;
        chk("op_idle", {62'd0, bus1.busy, bus1.resp0_valid | bus1.resp1_valid}, 64'd0);
        chk("op_ops_done", {48'd0, bus1.ops_done}, {48'd0, exp_ops});
    endtask

    initial begin
        int n;
        logic g;
        vecs[0] = '{1'b0, D_3P0, D_1P0, D_2P0};
        vecs[1] = '{1'b1, D_1P0, D_3P0, D_M2P0};
        vecs[2] = '{1'b0, 64'h4004000000000000, 64'h3FE0000000000000, D_2P0};
        vecs[3] = '{1'b1, 64'd0, 64'd0, 64'd0};
        vecs[4] = '{1'b0, D_1P0, D_1P0, 64'd0};
        vecs[5] = '{1'b1, 64'hBFF8000000000000, D_2P0, 64'hC00C000000000000};
        vecs[6] = '{1'b0, D_10P0, D_0P25, D_9P75};

        rst = 1'b1;
        bus1.req0_valid = 1'b1; bus1.req0_a = D_3P0; bus1.req0_b = D_1P0;
        bus1.req1_valid = 1'b0; bus1.req1_a = 64'd0; bus1.req1_b = 64'd0;
        bus1.resp0_ready = 1'b0; bus1.resp1_ready = 1'b0;
        bus4.req0_valid = 1'b0; bus4.req0_a = 64'd0; bus4.req0_b = 64'd0;
        bus4.req1_valid = 1'b0; bus4.req1_a = 64'd0; bus4.req1_b = 64'd0;
        bus4.resp0_ready = 1'b0; bus4.resp1_ready = 1'b0;

        // reset: outputs masked while rst is high, registers cleared after
        step();
        chk("rst_req0_ready", {63'd0, bus1.req0_ready}, 64'd0);
        chk("rst_busy", {63'd0, bus1.busy}, 64'd0);
        step();
        step();
        bus1.req0_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_flags", {59'd0, bus1.busy, bus1.resp0_valid, bus1.resp1_valid,
                               bus1.req0_ready, bus1.req1_ready}, 64'd0);
        chk("post_rst_sub_a", bus1.sub_a, 64'd0);
        chk("post_rst_sub_b", bus1.sub_b, 64'd0);
        chk("post_rst_resp_data", bus1.resp_data, 64'd0);
        chk("post_rst_ops", {48'd0, bus1.ops_done}, 64'd0);
        chk("post_rst_busy4", {63'd0, bus4.busy}, 64'd0);

        // table of single-requester ops on the LATENCY=1 instance
        for (int i = 0; i < 7; i++)
            do_op(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].diff, 16'(i + 1));

        // fairness from reset with both requesters held valid
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus1.req0_valid = 1'b1; bus1.req0_a = D_3P0; bus1.req0_b = D_1P0;
        bus1.req1_valid = 1'b1; bus1.req1_a = D_1P0; bus1.req1_b = D_3P0;
        #1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!(bus1.req0_ready | bus1.req1_ready) && n < 20) begin step(); n++; end
            chk("fair_one_hot", {63'd0, bus1.req0_ready & bus1.req1_ready}, 64'd0);
            g = bus1.req1_ready;
            chk("fair_order", {63'd0, g}, 64'(i % 2));
            step();
            n = 0;
            while (!(g ? bus1.resp1_valid : bus1.resp0_valid) && n < 20) begin step(); n++; end
            chk("fair_data", bus1.resp_data, (i % 2 == 1) ? D_M2P0 : D_2P0);
            if (g) bus1.resp1_ready = 1'b1; else bus1.resp0_ready = 1'b1;
            step();
            bus1.resp0_ready = 1'b0;
            bus1.resp1_ready = 1'b0;
        end

        // rr is back at 0: req0 wins, then stall its response with req1 waiting
        #1;
        chk("stall_grant0", {62'd0, bus1.req0_ready, bus1.req1_ready}, 64'd2);
        step();
        bus1.req0_valid = 1'b0;
        step();
        bus1.resp1_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("stall_resp0_valid", {63'd0, bus1.resp0_valid}, 64'd1);
            chk("stall_resp1_valid", {63'd0, bus1.resp1_valid}, 64'd0);
            chk("stall_data", bus1.resp_data, D_2P0);
            chk("stall_req1_ready", {63'd0, bus1.req1_ready}, 64'd0);
            chk("stall_busy", {63'd0, bus1.busy}, 64'd1);
            step();
        end
        // req1 gives up before ever being granted
        bus1.req1_valid = 1'b0;
        bus1.resp1_ready = 1'b0;
        bus1.resp0_ready = 1'b1;
        step();
        bus1.resp0_ready = 1'b0;
        step();
        step();
        chk("abandon_idle", {63'd0, bus1.busy}, 64'd0);
        chk("abandon_ops", {48'd0, bus1.ops_done}, 64'd5);

        // LATENCY=4: operands held through WAIT, valid 5 edges after handshake
        bus4.req0_valid = 1'b1; bus4.req0_a = D_3P0; bus4.req0_b = D_1P0;
        #1;
        chk("lat4_grant", {63'd0, bus4.req0_ready}, 64'd1);
        step();
        bus4.req0_valid = 1'b0;
        bus4.req0_a = D_10P0;
        bus4.req0_b = D_0P25;
        for (int e = 1; e <= 4; e++) begin
            chk("lat4_not_yet", {63'd0, bus4.resp0_valid}, 64'd0);
            chk("lat4_sub_a", bus4.sub_a, D_3P0);
            chk("lat4_sub_b", bus4.sub_b, D_1P0);
            step();
        end
        chk("lat4_valid_edge5", {63'd0, bus4.resp0_valid}, 64'd1);
        chk("lat4_data", bus4.resp_data, D_2P0);
        bus4.resp0_ready = 1'b1;
        step();
        bus4.resp0_ready = 1'b0;
        chk("lat4_ops", {48'd0, bus4.ops_done}, 64'd1);

        // reset in WAIT abandons the op
        bus4.req1_valid = 1'b1; bus4.req1_a = D_10P0; bus4.req1_b = D_0P25;
        step();
        bus4.req1_valid = 1'b0;
        step();
        chk("rstwait_busy_before", {63'd0, bus4.busy}, 64'd1);
        rst = 1'b1;
        #1;
        chk("rstwait_masked", {61'd0, bus4.busy, bus4.resp0_valid, bus4.resp1_valid}, 64'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("rstwait_quiet", {61'd0, bus4.busy, bus4.resp0_valid, bus4.resp1_valid}, 64'd0);
            step();
        end
        chk("rstwait_ops", {48'd0, bus4.ops_done}, 64'd0);
        bus4.req0_valid = 1'b1; bus4.req0_a = D_10P0; bus4.req0_b = D_0P25;
        #1;
        chk("rstwait_regrant", {63'd0, bus4.req0_ready}, 64'd1);
        step();
        bus4.req0_valid = 1'b0;
        n = 1;
        while (!bus4.resp0_valid && n < 20) begin step(); n++; end
        chk("rstwait_latency", 64'(n), 64'd5);
        chk("rstwait_data", bus4.resp_data, D_9P75);
        bus4.resp0_ready = 1'b1;
        step();
        bus4.resp0_ready = 1'b0;
        chk("rstwait_ops_after", {48'd0, bus4.ops_done}, 64'd1);

        // ops_done wrap
        force u_dut1.ops_q = 16'hFFFF;
        step();
        release u_dut1.ops_q;
        step();
        chk("wrap_preload", {48'd0, bus1.ops_done}, 64'hFFFF);
        do_op(1'b0, D_3P0, D_1P0, D_2P0, 16'h0000);
        do_op(1'b1, D_1P0, D_3P0, D_M2P0, 16'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fpu_sub_arbiter.md
FPU_SUB_ARBITER -- requirements
Module: fpu_sub_arbiter

Interface
REQ-001 Parameter LATENCY, default 1, is the number of cycles the shared subtractor needs to settle; the legal range SHALL be 1..15.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req0_valid / req1_valid  input  1  requester N presents an operand pair.
REQ-005 req0_ready / req1_ready  output  1  arbiter accepts requester N's pair this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  64  IEEE-754 double operands; the result is a-b.
REQ-007 resp0_valid / resp1_valid  output  1  result available for requester N.
REQ-008 resp0_ready / resp1_ready  input  1  requester N consumes its result.
REQ-009 resp_data  output  64  registered result, shared by both response ports.
REQ-010 sub_a, sub_b  output  64  registered operands driven to the shared dut subtractor.
REQ-011 sub_c  input  64  combinational difference returned by the dut.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 ops_done  output  16  count of completed response handshakes.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-015 In IDLE, at most one reqN_ready SHALL be high per cycle, and only for the granted port.
 - Grant rule: a lone valid requester wins.
 - If both are valid, the round-robin pointer rr selects the winner.
 - ready is combinational on valid and rr.
REQ-016 On a request handshake (valid & ready), the arbiter SHALL:
 - load sub_a/sub_b from the winner;
 - record the winner in gnt;
 - load cnt=LATENCY;
 - go to WAIT.
REQ-017 In WAIT, both req ready signals SHALL be 0, and cnt SHALL decrement each cycle.
REQ-018 When cnt==1 in WAIT, on that edge the arbiter SHALL latch sub_c into resp_data and go to RESP.
 - WAIT lasts exactly LATENCY cycles.
REQ-019 In RESP, resp<gnt>_valid SHALL be 1, the other resp valid SHALL be 0, and both req ready signals SHALL be 0.
REQ-020 resp_data and resp<gnt>_valid SHALL be held stable until resp<gnt>_ready is high.
REQ-021 On the response handshake, the arbiter SHALL:
 - go to IDLE;
 - set rr to the port that did not win (rr = ~gnt);
 - increment ops_done.
REQ-022 ops_done SHALL wrap from 0xFFFF to 0x0000 without saturating.
REQ-023 Latency: request handshake at edge k gives resp valid from edge k+LATENCY+1 onward.
 - A new request can be accepted no earlier than the cycle after the response handshake.
REQ-024 respN_ready inputs received outside RESP, or on the non-granted port, SHALL be ignored.
REQ-025 sub_a and sub_b SHALL hold their last operands after IDLE; the dut input SHALL NOT change during WAIT or RESP.
REQ-026 A requester that drops valid before being granted SHALL NOT be serviced, and no state SHALL be changed.
REQ-027 Back-to-back fairness: if both requesters hold valid continuously, grants SHALL alternate 0,1,0,1,... after reset.

Reset
REQ-028 When rst is high at a rising edge, the block SHALL enter IDLE and set:
 - rr=0, gnt=0, cnt=0;
 - sub_a=0, sub_b=0, resp_data=0;
 - ops_done=0.
REQ-029 During reset and the cycle after it, all valid/ready outputs and busy SHALL be 0, except the combinational IDLE reqN_ready from the second cycle onward.
REQ-030 A reset asserted in WAIT or RESP SHALL abandon the transaction.
 - No response is emitted for it.
 - ops_done is cleared.

Verification
REQ-031 LATENCY=1, dut connected:
 - req0 a=0x4008000000000000 (3.0), b=0x3FF0000000000000 (1.0);
 - response: resp0_valid two edges after the handshake, with resp_data=0x4000000000000000 (2.0);
 - ops_done=1 after resp0_ready.
REQ-032 Both requesters valid in the same cycle after reset:
 - req0 is granted first and req1 second;
 - with both held, the grant order is 0,1,0,1.
REQ-033 resp0_ready held low for 10 cycles in RESP:
 - resp0_valid and resp_data stay constant;
 - req1_ready stays 0;
 - busy stays 1.
REQ-034 LATENCY=4:
 - resp valid rises exactly 5 edges after the request handshake;
 - sub_a and sub_b are unchanged throughout WAIT.
REQ-035 rst pulsed during WAIT:
 - no resp valid appears;
 - ops_done=0, state IDLE;
 - a following request completes normally.
REQ-036 Preload ops_done=0xFFFF by forcing or running 65535 ops; the next completed op reads ops_done=0x0000.
